// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state enums shared by the ALU arbiter files
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester operation bus plus response channel
interface alu_arbiter_if;

    logic       req0_valid;
    logic [2:0] req0_op;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;

    logic       req1_valid;
    logic [2:0] req1_op;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_ovf;
    logic       rsp_dz;
    logic       busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_dz, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_dz, busy
    );

endinterface

// File: rtl/alu4_core.sv
// rtl/alu4_core.sv - purely combinational 4-bit ALU with carry, overflow and divide-by-zero flags
module alu4_core
    import alu_pkg::*;
(
    input  op_e        op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] result,
    output logic       carry,
    output logic       ovf,
    output logic       dz
);

    logic [4:0] sum;
    logic [4:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // bit 4 of the difference is the borrow, so carry is its inverse
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = 8'd0;
        carry  = 1'b0;
        ovf    = 1'b0;
        dz     = 1'b0;
        case (op)
            OP_ADD: begin
                result = {4'd0, sum[3:0]};
                carry  = sum[4];
                ovf    = (a[3] & b[3] & ~sum[3]) | (~a[3] & ~b[3] & sum[3]);
            end
            OP_SUB: begin
                result = {4'd0, diff[3:0]};
                carry  = ~diff[4];
                ovf    = (a[3] & ~b[3] & ~diff[3]) | (~a[3] & b[3] & diff[3]);
            end
            OP_MUL: result = {4'd0, a} * {4'd0, b};
            OP_DIV: begin
                if (b == 4'd0) begin
                    dz = 1'b1;
                end else begin
                    result = {a % b, a / b};
                end
            end
            OP_AND: result = {4'd0, a & b};
            OP_OR:  result = {4'd0, a | b};
            OP_XOR: result = {4'd0, a ^ b};
            OP_NOT: result = {4'd0, ~a};
            default: result = 8'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter feeding one ALU op at a time through IDLE/EXEC/RESP
module alu_arbiter
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_e     state;
    state_e     state_next;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       busy_c;
    logic       rsp_valid_c;

    op_e        cap_op;
    logic [3:0] cap_a;
    logic [3:0] cap_b;
    logic       cap_id;

    logic [7:0] result_q;
    logic       carry_q;
    logic       ovf_q;
    logic       dz_q;

    logic [7:0] core_result;
    logic       core_carry;
    logic       core_ovf;
    logic       core_dz;

    // with both requesting, favour the one not served last
    assign grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;

    assign bus.req0_ready = (state == ST_IDLE) & ~rst & bus.req0_valid & ~grant;
    assign bus.req1_ready = (state == ST_IDLE) & ~rst & bus.req1_valid & grant;
    assign accept         = bus.req0_ready | bus.req1_ready;

    always_comb begin
        state_next  = state;
        busy_c      = 1'b1;
        rsp_valid_c = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (accept) state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            cap_op     <= OP_ADD;
            cap_a      <= 4'd0;
            cap_b      <= 4'd0;
            cap_id     <= 1'b0;
            result_q   <= 8'd0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                cap_id     <= grant;
                cap_op     <= grant ? op_e'(bus.req1_op) : op_e'(bus.req0_op);
                cap_a      <= grant ? bus.req1_a : bus.req0_a;
                cap_b      <= grant ? bus.req1_b : bus.req0_b;
            end
            if (state == ST_EXEC) begin
                result_q <= core_result;
                carry_q  <= core_carry;
                ovf_q    <= core_ovf;
                dz_q     <= core_dz;
            end
        end
    end

    alu4_core u_core (
        .op     (cap_op),
        .a      (cap_a),
        .b      (cap_b),
        .result (core_result),
        .carry  (core_carry),
        .ovf    (core_ovf),
        .dz     (core_dz)
    );

    assign bus.busy       = busy_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_id     = cap_id;
    assign bus.rsp_result = result_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_dz     = dz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;

    typedef struct {
        bit         id;
        logic [7:0] res;
        bit         c;
        bit         o;
        bit         z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors   = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   acc_log[$];

    bit         r_valid[2];
    logic [2:0] r_op[2];
    logic [3:0] r_a[2];
    logic [3:0] r_b[2];
    bit         rr;

    // model: 0 idle, 1 computing, 2 holding a response
    int m_st;
    bit m_last;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t ref_op(bit id, int op, int a, int b);
        exp_t e;
        int   sa;
        int   sbv;
        sa  = (a >= 8) ? a - 16 : a;
        sbv = (b >= 8) ? b - 16 : b;
        e.id = id; e.res = 8'd0; e.c = 1'b0; e.o = 1'b0; e.z = 1'b0;
        case (op)
            0: begin
                e.res = 8'((a + b) % 16);
                e.c   = (a + b) >= 16;
                e.o   = (sa + sbv > 7) || (sa + sbv < -8);
            end
            1: begin
                e.res = 8'((a - b + 16) % 16);
                e.c   = a >= b;
                e.o   = (sa - sbv > 7) || (sa - sbv < -8);
            end
            2: e.res = 8'(a * b);
            3: begin
                if (b == 0) e.z = 1'b1;
                else        e.res = 8'((a % b) * 16 + a / b);
            end
            4: e.res = 8'(a & b);
            5: e.res = 8'(a | b);
            6: e.res = 8'(a ^ b);
            default: e.res = 8'(15 - a);
        endcase
        return e;
    endfunction

    task automatic set_req(int n, int op, int a, int b);
        r_valid[n] = 1'b1;
        r_op[n]    = 3'(op);
        r_a[n]     = 4'(a);
        r_b[n]     = 4'(b);
    endtask

    // one clock: drive, compare handshake/status against the model, advance model
    task automatic step();
        bit g;
        bit e0;
        bit e1;
        bus.req0_valid = r_valid[0]; bus.req0_op = r_op[0]; bus.req0_a = r_a[0]; bus.req0_b = r_b[0];
        bus.req1_valid = r_valid[1]; bus.req1_op = r_op[1]; bus.req1_a = r_a[1]; bus.req1_b = r_b[1];
        bus.rsp_ready  = rr;
        #1;
        e0 = 1'b0; e1 = 1'b0; g = 1'b0;
        if (m_st == 0) begin
            if (r_valid[0] && r_valid[1]) g = ~m_last;
            else                          g = r_valid[1];
            if (r_valid[g]) begin
                if (g) e1 = 1'b1;
                else   e0 = 1'b1;
            end
        end
        check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
        check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
        check("busy", {31'd0, bus.busy}, (m_st != 0) ? 32'd1 : 32'd0);
        check("rsp_valid", {31'd0, bus.rsp_valid}, (m_st == 2) ? 32'd1 : 32'd0);
        if (bus.req0_valid && bus.req0_ready) acc_log.push_back(0);
        if (bus.req1_valid && bus.req1_ready) acc_log.push_back(1);
        case (m_st)
            0: if (e0 || e1) begin
                sb.push_back(ref_op(g, int'(r_op[g]), int'(r_a[g]), int'(r_b[g])));
                m_last     = g;
                r_valid[g] = 1'b0;
                m_st       = 1;
            end
            1: m_st = 2;
            default: if (rr) m_st = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n  = 0;
        rr = 1'b1;
        while ((m_st != 0 || r_valid[0] || r_valid[1]) && n < 60) begin
            step();
            n++;
        end
        check("drain_timeout", n, (n < 60) ? n : 0);
    endtask

    task automatic zero_checks(string tag);
        check({tag, "_outputs"}, {18'd0, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_carry,
                                  bus.rsp_ovf, bus.rsp_dz, bus.rsp_result}, 32'd0);
        check({tag, "_ready"}, {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    endtask

    task automatic pulse_reset(string tag);
        #3 rst = 1'b1;
        #1 zero_checks(tag);
        sb.delete();
        m_st = 0; m_last = 1'b1;
        r_valid[0] = 1'b0; r_valid[1] = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: every cycle a response is shown it must equal the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.rsp_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got id=%0d res=%02h expected no response",
                             bus.rsp_id, bus.rsp_result);
                end else begin
                    e = sb[0];
                    if (bus.rsp_id !== e.id || bus.rsp_result !== e.res || bus.rsp_carry !== e.c ||
                        bus.rsp_ovf !== e.o || bus.rsp_dz !== e.z) begin
                        miscompares++;
                        $display("FAIL rsp: got id=%0d res=%02h c=%0d o=%0d z=%0d expected id=%0d res=%02h c=%0d o=%0d z=%0d",
                                 bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_ovf, bus.rsp_dz,
                                 e.id, e.res, e.c, e.o, e.z);
                    end
                    if (bus.rsp_ready === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        m_st = 0; m_last = 1'b1; rr = 1'b1;
        for (int n = 0; n < 2; n++) begin
            r_valid[n] = 1'b0; r_op[n] = 3'd0; r_a[n] = 4'd0; r_b[n] = 4'd0;
        end
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        zero_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        // ADD with signed overflow and carry
        set_req(0, 0, 9, 8);
        drain();

        // both requesting continuously: grants must alternate from req0
        pulse_reset("rst_idle");
        base = acc_log.size();
        for (int k = 0; k < 12; k++) begin
            if (!r_valid[0]) set_req(0, 1, 3, 5);
            if (!r_valid[1]) set_req(1, 2, 15, 15);
            step();
        end
        drain();
        for (int k = 0; k < 4; k++)
            check("rr_order", (acc_log.size() > base + k) ? acc_log[base + k] : 9, k % 2);

        // division and divide-by-zero
        set_req(1, 3, 13, 4);
        drain();
        set_req(1, 3, 7, 0);
        drain();

        // response back-pressure with both requesters waiting
        set_req(0, 4, 12, 10);
        rr = 1'b0;
        step();
        step();
        set_req(0, 6, 5, 3);
        set_req(1, 7, 6, 0);
        for (int k = 0; k < 5; k++) step();
        drain();

        // reset mid-EXEC and mid-RESP, then req0 must win a simultaneous pair
        set_req(0, 2, 7, 6);
        rr = 1'b1;
        step();
        pulse_reset("rst_exec");
        set_req(1, 5, 9, 3);
        step();
        step();
        pulse_reset("rst_resp");
        base = acc_log.size();
        set_req(0, 0, 1, 2);
        set_req(1, 0, 3, 4);
        drain();
        check("post_reset_grant", (acc_log.size() > base) ? acc_log[base] : 9, 0);

        // random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++)
                if (!r_valid[n] && $urandom_range(0, 2) == 0)
                    set_req(n, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
            rr = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; the requester count is fixed at 2 and the operand width is fixed at 4.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_op  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT.
REQ-006 reqN_a, reqN_b  in  4 each  unsigned operands.
REQ-007 reqN_ready  out  1  request accepted this cycle when valid and ready are both high.
REQ-008 rsp_valid  out  1  response available.
REQ-009 rsp_ready  in  1  consumer takes the response.
REQ-010 rsp_id  out  1  index of the requester that owns the response.
REQ-011 rsp_result  out  8  ALU result.
REQ-012 rsp_carry, rsp_ovf, rsp_dz  out  1 each  carry/no-borrow flag, signed overflow flag, divide-by-zero flag.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP; no other states are reachable.
REQ-015 IDLE: at most one reqN_ready SHALL be high, only for the granted requester, and only while that requester's valid is high (combinational from valid and the grant pointer).
REQ-016 Arbitration SHALL be round-robin: with both valid, grant goes to the requester not granted last; with one valid, grant goes to that one.
REQ-017 On acceptance the block SHALL capture op, a, b and the id, and move IDLE->EXEC.
REQ-018 EXEC SHALL last exactly one cycle, compute via the ALU core, register result and flags, and move to RESP.
REQ-019 rsp_valid SHALL rise 2 cycles after the acceptance edge and remain high, with all rsp_* outputs stable, until rsp_valid&rsp_ready; RESP then moves to IDLE.
REQ-020 No request SHALL be accepted in EXEC or RESP; a new acceptance is possible in the first IDLE cycle after the response handshake, so sustained throughput is one operation per 3 cycles.
REQ-021 ADD: result[3:0]=a+b, result[7:4]=0, carry=bit 4 of the 5-bit sum, ovf=(a3&b3&~s3)|(~a3&~b3&s3).
REQ-022 SUB: result[3:0]=a-b mod 16, result[7:4]=0, carry=1 when a>=b (no borrow), ovf=(a3&~b3&~d3)|(~a3&b3&d3).
REQ-023 MUL: result = 8-bit unsigned a*b (15*15=225).
REQ-024 DIV: result[7:4]=a%b, result[3:0]=a/b; when b=0, result=0 and rsp_dz=1.
REQ-025 AND/OR/XOR/NOT: result[3:0]=a&b, a|b, a^b, ~a respectively; result[7:4]=0; for NOT, b is ignored.
REQ-026 carry and ovf SHALL be 0 for all ops except ADD and SUB; dz SHALL be 0 for all ops except DIV with b=0.
REQ-027 The grant pointer SHALL update only on acceptance.

Reset
REQ-028 Asserting rst at any time, including mid-EXEC or mid-RESP, SHALL immediately force IDLE, drop any in-flight operation, and drive rsp_valid=0, busy=0, rsp_result=0, rsp_id=0 and all flags 0.
REQ-029 After reset the grant pointer SHALL favour requester 0 (last-granted = 1).

Structure
REQ-030 A shared package alu_pkg SHALL hold the opcode constants/enum and the FSM state enum.
REQ-031 The arithmetic SHALL reside in one combinational sub-module, alu4_core (op, a, b -> result, carry, ovf, dz); the arbiter holds all state.

Verification
REQ-032 Req0 ADD a=9 b=8, rsp_ready=1 -> rsp_valid 2 cycles after accept, result=0x01, carry=1, ovf=1, id=0.
REQ-033 Req0 and req1 both valid continuously (req0 SUB 3-5, req1 MUL 15*15) -> grants alternate 0,1,0,1; responses: 0x0E carry=0 ovf=0, then 0xE1.
REQ-034 Req1 DIV a=13 b=4 then DIV a=7 b=0 -> 0x13 dz=0, then 0x00 dz=1.
REQ-035 rsp_ready held low for 5 cycles during RESP -> rsp_* stable, busy=1, both reqN_ready=0 throughout; completes one cycle after rsp_ready rises.
REQ-036 rst pulsed during EXEC and during RESP -> outputs zero immediately; the next simultaneous request pair is granted to req0 first.
